// File: rtl/geofence_xprod_sched.sv
// Geofence sequencer: loads a test point and six receivers, sorts them CCW,
// then runs the point-in-polygon edge test through a shared cross-product unit.
module geofence_xprod_sched #(
    parameter int CW         = 10,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          busy,
    output logic          xp_req,
    output logic [2*CW-1:0] xp_o,
    output logic [2*CW-1:0] xp_a,
    output logic [2*CW-1:0] xp_b,
    input  logic          xp_done,
    input  logic          xp_neg,
    input  logic          xp_zero,
    output logic          valid,
    output logic          is_inside
);

    typedef enum logic [1:0] {LOAD, SORT, TEST, DONE} state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [2:0]    j;
    logic [2:0]    k;
    logic [1:0]    pass;
    logic          adv;
    logic          res_neg;
    logic          res_zero;
    logic          all_pass;
    logic [CW-1:0] tx;
    logic [CW-1:0] ty;
    logic [CW-1:0] px [6];
    logic [CW-1:0] py [6];

    logic [2:0] j1;
    logic [2:0] k1;
    logic [2:0] j_last;
    logic       edge_fail;

    assign j1        = j + 3'd1;
    assign k1        = (k == 3'd5) ? 3'd0 : k + 3'd1;
    assign j_last    = 3'd4 - {1'b0, pass};
    assign edge_fail = res_neg | res_zero;

    // Operands are pure functions of the loop indices, which only move in ADV.
    always_comb begin
        xp_o = '0;
        xp_a = '0;
        xp_b = '0;
        unique case (1'b1)
            (state == SORT): begin
                xp_o = {px[0], py[0]};
                xp_a = {px[j], py[j]};
                xp_b = {px[j1], py[j1]};
            end
            (state == TEST): begin
                xp_o = {px[k], py[k]};
                xp_a = {px[k1], py[k1]};
                xp_b = {tx, ty};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            cnt       <= '0;
            j         <= 3'd1;
            k         <= '0;
            pass      <= '0;
            adv       <= 1'b0;
            res_neg   <= 1'b0;
            res_zero  <= 1'b0;
            all_pass  <= 1'b1;
            tx        <= '0;
            ty        <= '0;
            busy      <= 1'b0;
            xp_req    <= 1'b0;
            valid     <= 1'b0;
            is_inside <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            valid     <= 1'b0;
            is_inside <= 1'b0;
            case (state)
                LOAD: begin
                    if (cnt == 3'd0) begin
                        tx <= X;
                        ty <= Y;
                    end else begin
                        px[cnt - 3'd1] <= X;
                        py[cnt - 3'd1] <= Y;
                    end
                    if (cnt == 3'd6) begin
                        cnt    <= '0;
                        state  <= SORT;
                        busy   <= 1'b1;
                        xp_req <= 1'b1;
                        adv    <= 1'b0;
                        pass   <= '0;
                        j      <= 3'd1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                SORT: begin
                    if (!adv) begin
                        if (xp_done) begin
                            res_neg <= xp_neg;
                            xp_req  <= 1'b0;
                            adv     <= 1'b1;
                        end
                    end else begin
                        adv    <= 1'b0;
                        xp_req <= 1'b1;
                        if (res_neg) begin
                            px[j]  <= px[j1];
                            px[j1] <= px[j];
                            py[j]  <= py[j1];
                            py[j1] <= py[j];
                        end
                        if (j == j_last) begin
                            j <= 3'd1;
                            if (pass == 2'd3) begin
                                state    <= TEST;
                                k        <= '0;
                                all_pass <= 1'b1;
                            end else begin
                                pass <= pass + 2'd1;
                            end
                        end else begin
                            j <= j1;
                        end
                    end
                end
                TEST: begin
                    if (!adv) begin
                        if (xp_done) begin
                            res_neg  <= xp_neg;
                            res_zero <= xp_zero;
                            xp_req   <= 1'b0;
                            adv      <= 1'b1;
                        end
                    end else begin
                        adv <= 1'b0;
                        if (edge_fail)
                            all_pass <= 1'b0;
                        if ((edge_fail && EARLY_EXIT) || k == 3'd5) begin
                            state     <= DONE;
                            valid     <= 1'b1;
                            is_inside <= all_pass & ~edge_fail;
                        end else begin
                            k      <= k + 3'd1;
                            xp_req <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= LOAD;
                    busy  <= 1'b0;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_geofence_xprod_sched.sv
// Bench for geofence_xprod_sched: golden cross-product responder plus a
// sort/test reference model predicting every transaction and every result.
module tb_geofence_xprod_sched;

    localparam int CW = 10;
    localparam bit EE = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic          busy;
    logic          xp_req;
    logic [2*CW-1:0] xp_o;
    logic [2*CW-1:0] xp_a;
    logic [2*CW-1:0] xp_b;
    logic          xp_done;
    logic          xp_neg;
    logic          xp_zero;
    logic          valid;
    logic          is_inside;

    geofence_xprod_sched #(.CW(CW), .EARLY_EXIT(EE)) dut (
        .clk(clk), .reset(reset), .X(X), .Y(Y), .busy(busy),
        .xp_req(xp_req), .xp_o(xp_o), .xp_a(xp_a), .xp_b(xp_b),
        .xp_done(xp_done), .xp_neg(xp_neg), .xp_zero(xp_zero),
        .valid(valid), .is_inside(is_inside)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_req = 0;
    int n_valid = 0;
    int lat_mode = 0;
    bit stall_mode = 1'b0;
    int wcnt = 0;
    int c_r;
    bit req_active = 1'b0;
    logic [59:0] held;
    logic [59:0] e_op;
    logic [59:0] exp_ops[$];
    bit          exp_res[$];

    int ha_x[6] = '{600, 450, 550, 400, 550, 450};
    int ha_y[6] = '{500, 413, 587, 500, 413, 587};
    int hb_x[6] = '{600, 450, 550, 400, 550, 450};
    int hb_y[6] = '{500, 400, 600, 500, 400, 600};
    int cs[12] = '{1000, 866, 500, 0, -500, -866, -1000, -866, -500, 0, 500, 866};
    int sn[12] = '{0, 500, 866, 1000, 866, 500, 0, -500, -866, -1000, -866, -500};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int cr(input int ox, oy, ax, ay, bx, by);
        return (ax - ox) * (by - oy) - (ay - oy) * (bx - ox);
    endfunction

    function automatic logic [59:0] pk(input int ox, oy, ax, ay, bx, by);
        return {10'(ox), 10'(oy), 10'(ax), 10'(ay), 10'(bx), 10'(by)};
    endfunction

    function automatic int xprod(input logic [59:0] t);
        return cr(int'(t[59:50]), int'(t[49:40]), int'(t[39:30]),
                  int'(t[29:20]), int'(t[19:10]), int'(t[9:0]));
    endfunction

    // Reference: bubble sort around P0 by cross sign, then the six edge tests.
    task automatic model_set(input int tx, ty, input int ix[6], iy[6],
                             output bit res, output int ntx);
        int x[6];
        int y[6];
        int c;
        int t;
        int n;
        x = ix;
        y = iy;
        ntx = 0;
        for (int p = 0; p < 4; p++) begin
            for (int j = 1; j <= 4 - p; j++) begin
                exp_ops.push_back(pk(x[0], y[0], x[j], y[j], x[j+1], y[j+1]));
                ntx++;
                c = cr(x[0], y[0], x[j], y[j], x[j+1], y[j+1]);
                if (c < 0) begin
                    t = x[j]; x[j] = x[j+1]; x[j+1] = t;
                    t = y[j]; y[j] = y[j+1]; y[j+1] = t;
                end
            end
        end
        res = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = (k + 1) % 6;
            exp_ops.push_back(pk(x[k], y[k], x[n], y[n], tx, ty));
            ntx++;
            c = cr(x[k], y[k], x[n], y[n], tx, ty);
            if (c <= 0) begin
                res = 1'b0;
                if (EE) break;
            end
        end
        exp_res.push_back(res);
    endtask

    // Golden cross-product unit with configurable response delay.
    always @(negedge clk) begin
        if (reset) begin
            xp_done = 1'b0;
            xp_neg  = 1'b0;
            xp_zero = 1'b0;
            wcnt    = lat_mode;
        end else if (xp_req) begin
            if (wcnt == 0) begin
                c_r = xprod({xp_o, xp_a, xp_b});
                xp_done = 1'b1;
                xp_neg  = (c_r < 0);
                xp_zero = (c_r == 0);
            end else begin
                wcnt--;
                xp_done = 1'b0;
                xp_neg  = 1'($urandom % 2);
                xp_zero = 1'($urandom % 2);
            end
        end else begin
            xp_done = stall_mode ? 1'($urandom % 2) : 1'b0;
            xp_neg  = stall_mode ? 1'($urandom % 2) : 1'b0;
            xp_zero = stall_mode ? 1'($urandom % 2) : 1'b0;
            wcnt    = stall_mode ? int'($urandom_range(0, 5)) : lat_mode;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            req_active = 1'b0;
        end else begin
            if (xp_req) begin
                if (!req_active) begin
                    n_req++;
                    chk("req_expected", 64'(exp_ops.size() > 0), 64'd1);
                    if (exp_ops.size() > 0) begin
                        e_op = exp_ops.pop_front();
                        chk("xp_operands", 64'({xp_o, xp_a, xp_b}), 64'(e_op));
                    end
                    held = {xp_o, xp_a, xp_b};
                end else begin
                    chk("op_stable", 64'({xp_o, xp_a, xp_b}), 64'(held));
                end
                req_active = 1'b1;
            end else begin
                req_active = 1'b0;
            end
            if (valid) begin
                n_valid++;
                chk("valid_expected", 64'(exp_res.size() > 0), 64'd1);
                if (exp_res.size() > 0)
                    chk("is_inside", 64'(is_inside), 64'(exp_res.pop_front()));
            end
        end
    end

    task automatic run_set(input int tx, ty, input int ix[6], iy[6],
                           output bit res, output int ntx);
        int guard;
        model_set(tx, ty, ix, iy, res, ntx);
        guard = 0;
        while (busy && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("load_ready", 64'(busy), 64'd0);
        for (int i = 0; i < 7; i++) begin
            X = (i == 0) ? 10'(tx) : 10'(ix[i-1]);
            Y = (i == 0) ? 10'(ty) : 10'(iy[i-1]);
            @(posedge clk);
            @(negedge clk);
        end
        chk("busy_after_load", 64'(busy), 64'd1);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 7;
        while (!valid && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("valid_seen", 64'(valid), 64'd1);
        @(negedge clk);
        chk("valid_pulse", 64'(valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit res;
        int ntx;
        int cyc;
        int r0;
        int guard;
        int target;
        int rx[6];
        int ry[6];
        int idx[12];
        int cx, cy, rr, tx, ty, sj, t;

        reset = 1'b1;
        X = '0;
        Y = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_xp_req", 64'(xp_req), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_is_inside", 64'(is_inside), 64'd0);
        reset = 1'b0;

        // Inside, zero-wait
        r0 = n_req;
        run_set(500, 500, ha_x, ha_y, res, ntx);
        wait_valid(cyc);
        chk("model_inside", 64'(res), 64'd1);
        chk("inside_ntx", 64'(ntx), 64'd16);
        chk("inside_reqs", 64'(n_req - r0), 64'd16);
        chk("inside_latency0", 64'(cyc), 64'd39);

        // Inside, one wait cycle per transaction
        lat_mode = 1;
        run_set(500, 500, ha_x, ha_y, res, ntx);
        wait_valid(cyc);
        chk("inside_latency1", 64'(cyc), 64'd55);
        lat_mode = 0;

        // Outside with early exit
        r0 = n_req;
        run_set(10, 10, ha_x, ha_y, res, ntx);
        wait_valid(cyc);
        chk("model_outside", 64'(res), 64'd0);
        chk("outside_ntx", 64'(ntx), 64'd13);
        chk("outside_reqs", 64'(n_req - r0), 64'd13);
        chk("outside_latency", 64'(cyc), 64'd33);

        // Exactly on an edge
        r0 = n_req;
        run_set(575, 550, hb_x, hb_y, res, ntx);
        wait_valid(cyc);
        chk("model_onedge", 64'(res), 64'd0);
        chk("onedge_reqs", 64'(n_req - r0), 64'd11);

        // Random stalls and stray xp_done pulses
        stall_mode = 1'b1;
        for (int s = 0; s < 3; s++) begin
            r0 = n_req;
            run_set(500, 500, ha_x, ha_y, res, ntx);
            wait_valid(cyc);
            chk("stall_reqs", 64'(n_req - r0), 64'd16);
        end
        stall_mode = 1'b0;

        // Reset in the middle of SORT
        r0 = n_req;
        run_set(500, 500, ha_x, ha_y, res, ntx);
        guard = 0;
        while (!(xp_req && (n_req - r0) >= 4) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("reached_sort", 64'(xp_req), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_xp_req", 64'(xp_req), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(valid), 64'd0);
        exp_ops.delete();
        exp_res.delete();
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        r0 = n_req;
        run_set(500, 500, ha_x, ha_y, res, ntx);
        wait_valid(cyc);
        chk("post_rst_reqs", 64'(n_req - r0), 64'd16);

        // Back-to-back random convex sets
        stall_mode = 1'b1;
        target = n_valid + 50;
        for (int s = 0; s < 50; s++) begin
            for (int i = 0; i < 12; i++) idx[i] = i;
            for (int i = 11; i > 0; i--) begin
                sj = int'($urandom_range(0, i));
                t = idx[i]; idx[i] = idx[sj]; idx[sj] = t;
            end
            cx = int'($urandom_range(300, 700));
            cy = int'($urandom_range(300, 700));
            rr = int'($urandom_range(50, 250));
            for (int i = 0; i < 6; i++) begin
                rx[i] = cx + (rr * cs[idx[i]]) / 1000;
                ry[i] = cy + (rr * sn[idx[i]]) / 1000;
            end
            tx = cx + int'($urandom_range(0, 2 * rr + 40)) - rr - 20;
            ty = cy + int'($urandom_range(0, 2 * rr + 40)) - rr - 20;
            run_set(tx, ty, rx, ry, res, ntx);
        end
        guard = 0;
        while (n_valid < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("b2b_valid_count", 64'(n_valid), 64'(target));
        chk("b2b_ops_drained", 64'(exp_ops.size()), 64'd0);
        @(negedge clk);
        chk("final_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
